xor3_parity_seq: RTL



---
 rtl/xor3_parity_seq.sv | 100 ++++++++++
 1 files changed

// File: rtl/xor3_parity_seq.sv
// Sequential parity generator: reduces a WIDTH-bit word two bits per clock
// through a single shared xor3 cell, with a start/busy/done handshake.
`timescale 1ns/1ps

module xor3 (
    input  logic in1,
    input  logic in2,
    input  logic in3,
    output logic out
);
    assign out = in1 ^ in2 ^ in3;
endmodule

module xor3_parity_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             odd_mode,
    output logic             busy,
    output logic             done,
    output logic             parity_out
);
    localparam int CW = $clog2(WIDTH / 2) + 1;
    localparam logic [CW-1:0] HALF = CW'(WIDTH / 2);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh;
    logic             acc;
    logic             mode;
    logic [CW-1:0]    cnt;
    logic             x_out;

    // The one shared reduction cell: the low pair of the shift register folded
    // into the running accumulator.
    xor3 u_xor3 (
        .in1 (sh[1]),
        .in2 (sh[0]),
        .in3 (acc),
        .out (x_out)
    );

    // NOTE: all state uses non-blocking assignments so every register sees
    // pre-edge values, which keeps x_out consistent with the sh/acc it came from.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            parity_out <= 1'b0;
            sh         <= '0;
            acc        <= 1'b0;
            mode       <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sh    <= data_in;
                        acc   <= 1'b0;
                        mode  <= odd_mode;
                        cnt   <= HALF;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= x_out;
                    sh  <= sh >> 2;
                    cnt <= cnt - ONE;
                    // Last pair consumed on this edge: publish the result.
                    if (cnt == ONE) begin
                        parity_out <= x_out ^ mode;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
